// File: rtl/crc_engine_param.sv
`default_nettype none
// ---------------------------------------------------------------------------
// crc_engine_param : serial CRC generator/checker with MSB-first CRC sender
// Revision 1.0
// ---------------------------------------------------------------------------
module crc_engine_param #(
  parameter int              CRC_W    = 16,
  parameter logic [CRC_W-1:0] POLY     = 16'h8005,
  parameter logic [CRC_W-1:0] INIT     = '1,
  parameter logic [CRC_W-1:0] RESIDUAL = 16'h800D
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             clear,
  input  logic             bit_valid,
  input  logic             bit_in,
  input  logic             data_end,
  input  logic             send_ready,
  output logic             serial_out,
  output logic             serial_valid,
  output logic [CRC_W-1:0] crc_value,
  output logic             crc_ok,
  output logic             busy,
  output logic             done
);

  localparam int CNT_W = $clog2(CRC_W + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    SEND = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [CRC_W-1:0] crc_q, crc_d;
  logic [CRC_W-1:0] shift_q, shift_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CRC_W-1:0] crc_upd;
  logic [CRC_W-1:0] crc_in;

  function automatic logic [CRC_W-1:0] crc_step(input logic [CRC_W-1:0] r, input logic b);
    logic fb;
    fb = b ^ r[CRC_W-1];
    return {r[CRC_W-2:0], 1'b0} ^ (fb ? POLY : '0);
  endfunction

  always_comb begin
    crc_upd = crc_step(crc_q, bit_in);
    crc_in  = bit_valid ? crc_upd : crc_q;
    state_d = state_q;
    crc_d   = crc_q;
    shift_d = shift_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE, CALC: begin
        // A bit arriving with data_end is absorbed before the CRC is latched for sending.
        crc_d = crc_in;
        if (data_end) begin
          state_d = SEND;
          shift_d = ~crc_in;
          cnt_d   = CNT_W'(CRC_W);
        end else if (bit_valid) begin
          state_d = CALC;
        end
      end
      SEND: begin
        if (send_ready) begin
          shift_d = {shift_q[CRC_W-2:0], 1'b0};
          cnt_d   = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
        crc_d   = INIT;
      end
      default: state_d = IDLE;
    endcase
    if (clear) begin
      state_d = IDLE;
      crc_d   = INIT;
      shift_d = '0;
      cnt_d   = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state_q <= IDLE;
      crc_q   <= INIT;
      shift_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      crc_q   <= crc_d;
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
    end
  end

  assign serial_valid = (state_q == SEND);
  assign serial_out   = serial_valid & shift_q[CRC_W-1];
  assign crc_value    = ~crc_q;
  assign crc_ok       = (crc_q == RESIDUAL[CRC_W-1:0]);
  assign busy         = (state_q != IDLE);
  assign done         = (state_q == DONE);

endmodule
`default_nettype wire

// File: tb/tb_crc_engine_param.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_crc_engine_param : scoreboard bench for CRC5 and default CRC16 engines
// Revision 1.0
// ---------------------------------------------------------------------------
module tb_crc_engine_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic n_rst;
  logic clr5, bv5, bi5, de5, sr5;
  logic so5, sv5, ok5, busy5, done5;
  logic [4:0] cv5;
  logic clr16, bv16, bi16, de16, sr16;
  logic so16, sv16, ok16, busy16, done16;
  logic [15:0] cv16;

  crc_engine_param #(.CRC_W(5), .POLY(5'h05), .INIT(5'h1F), .RESIDUAL(5'h0C)) u_crc5 (
    .clk(clk), .n_rst(n_rst), .clear(clr5), .bit_valid(bv5), .bit_in(bi5),
    .data_end(de5), .send_ready(sr5), .serial_out(so5), .serial_valid(sv5),
    .crc_value(cv5), .crc_ok(ok5), .busy(busy5), .done(done5)
  );

  crc_engine_param u_crc16 (
    .clk(clk), .n_rst(n_rst), .clear(clr16), .bit_valid(bv16), .bit_in(bi16),
    .data_end(de16), .send_ready(sr16), .serial_out(so16), .serial_valid(sv16),
    .crc_value(cv16), .crc_ok(ok16), .busy(busy16), .done(done16)
  );

  int   n_cmp = 0;
  int   n_fail = 0;
  logic q5[$];
  logic q16[$];
  int   acc5 = 0;
  int   acc16 = 0;
  int   dn16 = 0;
  logic [4:0]  m5r;
  logic [15:0] m16r;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h", nm, act, exp);
    end
  endtask

  function automatic logic [4:0] m5(input logic [4:0] r, input logic b);
    return {r[3:0], 1'b0} ^ ((b ^ r[4]) ? 5'h05 : 5'h00);
  endfunction

  function automatic logic [15:0] m16(input logic [15:0] r, input logic b);
    return {r[14:0], 1'b0} ^ ((b ^ r[15]) ? 16'h8005 : 16'h0000);
  endfunction

  // Monitors: compare each presented serial bit with the queue head; pop on accept.
  always @(negedge clk) begin
    if (sv5 === 1'b1) begin
      if (q5.size() == 0) chk("crc5 unexpected serial bit", 32'd1, 32'd0);
      else begin
        chk("crc5 serial_out", so5, q5[0]);
        if (sr5) begin
          void'(q5.pop_front());
          acc5++;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (done16 === 1'b1) dn16++;
    if (sv16 === 1'b1) begin
      if (q16.size() == 0) chk("crc16 unexpected serial bit", 32'd1, 32'd0);
      else begin
        chk("crc16 serial_out", so16, q16[0]);
        if (sr16) begin
          void'(q16.pop_front());
          acc16++;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic feed5(input logic [31:0] bits, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      bv5 = 1'b1; bi5 = bits[i];
      m5r = m5(m5r, bits[i]);
      tick();
    end
    bv5 = 1'b0; bi5 = 1'b0;
  endtask

  task automatic feed16(input logic [31:0] bits, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      bv16 = 1'b1; bi16 = bits[i];
      m16r = m16(m16r, bits[i]);
      tick();
    end
    bv16 = 1'b0; bi16 = 1'b0;
  endtask

  task automatic end16_model();
    for (int i = 15; i >= 0; i--) q16.push_back(~m16r[i]);
    de16 = 1'b1; tick(); de16 = 1'b0;
  endtask

  task automatic wait_done5(input string nm);
    int k;
    k = 0;
    while (done5 !== 1'b1 && k < 100) begin tick(); k++; end
    chk(nm, done5, 1);
    tick();
    m5r = 5'h1F;
  endtask

  task automatic wait_done16(input string nm);
    int k;
    k = 0;
    while (done16 !== 1'b1 && k < 100) begin tick(); k++; end
    chk(nm, done16, 1);
    tick();
    m16r = 16'hFFFF;
  endtask

  initial begin
    int c, bad, dn;
    n_rst = 1'b0;
    {clr5, bv5, bi5, de5, sr5} = '0;
    {clr16, bv16, bi16, de16, sr16} = '0;
    m5r = 5'h1F; m16r = 16'hFFFF;
    tick(); tick();
    chk("reset serial_out", so5, 0);
    chk("reset serial_valid", sv5, 0);
    chk("reset busy", busy5, 0);
    chk("reset done", done5, 0);
    chk("reset crc5 value", cv5, 5'h00);
    chk("reset crc16 value", cv16, 16'h0000);
    n_rst = 1'b1;
    tick();

    // CRC5: eleven zeros, then send with send_ready held high
    feed5(32'h0, 11);
    q5.push_back(1'b0); q5.push_back(1'b1); q5.push_back(1'b0);
    q5.push_back(1'b0); q5.push_back(1'b0);
    sr5 = 1'b1; de5 = 1'b1; tick(); de5 = 1'b0;
    chk("s1 crc_value", cv5, 5'b01000);
    chk("s1 serial_valid", sv5, 1);
    repeat (4) tick();
    chk("s1 no early done", done5, 0);
    tick();
    chk("s1 done after 5th bit", done5, 1);
    chk("s1 crc frozen in done", cv5, 5'b01000);
    tick();
    chk("s1 done single cycle", done5, 0);
    chk("s1 idle busy", busy5, 0);
    chk("s1 init reload", cv5, 5'h00);
    chk("s1 queue drained", q5.size(), 0);
    m5r = 5'h1F;

    // CRC5 check mode: payload plus its CRC gives the residual
    feed5(32'h0008, 16);
    chk("s2 crc_ok good frame", ok5, 1);
    chk("s2 raw residual", cv5, 5'b10011);
    clr5 = 1'b1; tick(); clr5 = 1'b0;
    chk("s2 clear reload", cv5, 5'h00);
    for (int j = 0; j < 16; j++) begin
      feed5(32'h0008 ^ (32'd1 << j), 16);
      chk($sformatf("s2 crc_ok flip bit %0d", j), ok5, 0);
      clr5 = 1'b1; tick(); clr5 = 1'b0;
    end
    m5r = 5'h1F;

    // CRC16: empty payload
    acc16 = 0;
    for (int i = 0; i < 16; i++) q16.push_back(1'b0);
    sr16 = 1'b1; de16 = 1'b1; tick(); de16 = 1'b0;
    chk("s3 crc16 empty value", cv16, 16'h0000);
    chk("s3 crc16 serial_valid", sv16, 1);
    wait_done16("s3 crc16 done");
    chk("s3 crc16 accepts", acc16, 16);
    chk("s3 queue drained", q16.size(), 0);

    // CRC5: send_ready toggling 1,0,0,1
    feed5(32'hA5, 8);
    for (int i = 4; i >= 0; i--) q5.push_back(~m5r[i]);
    sr5 = 1'b1; de5 = 1'b1; tick(); de5 = 1'b0;
    acc5 = 0; c = 0; bad = 0;
    while (done5 !== 1'b1 && c < 100) begin
      sr5 = ((c % 4) == 0) || ((c % 4) == 3);
      if (sv5 !== 1'b1) bad++;
      tick();
      c++;
    end
    chk("s4 done reached", done5, 1);
    chk("s4 accept count", acc5, 5);
    chk("s4 serial_valid gaps", bad, 0);
    chk("s4 queue drained", q5.size(), 0);
    sr5 = 1'b1;
    tick();
    m5r = 5'h1F;

    // CRC16: clear at the 8th SEND bit, then n_rst at the 8th SEND bit
    for (int v = 0; v < 2; v++) begin
      feed16(32'h31, 8);
      end16_model();
      repeat (7) tick();
      dn = dn16;
      if (v == 0) clr16 = 1'b1; else n_rst = 1'b0;
      tick();
      clr16 = 1'b0; n_rst = 1'b1;
      chk($sformatf("s5 abort%0d serial_valid", v), sv16, 0);
      chk($sformatf("s5 abort%0d busy", v), busy16, 0);
      q16.delete();
      repeat (3) tick();
      chk($sformatf("s5 abort%0d no done", v), dn16, dn);
      m16r = 16'hFFFF;
    end
    feed16(32'h313233, 24);
    end16_model();
    chk("s5 next frame crc_value", cv16, {16'd0, ~m16r});
    wait_done16("s5 next frame done");
    chk("s5 queue drained", q16.size(), 0);

    // CRC5: bit_valid and data_end in the same CALC cycle
    feed5(32'b101, 3);
    q5.push_back(1'b1); q5.push_back(1'b1); q5.push_back(1'b0);
    q5.push_back(1'b1); q5.push_back(1'b1);
    bv5 = 1'b1; bi5 = 1'b1; de5 = 1'b1; tick();
    bv5 = 1'b0; bi5 = 1'b0; de5 = 1'b0;
    chk("s6 same-cycle bit crc_value", cv5, 5'h1B);
    wait_done5("s6 done");
    chk("s6 queue drained", q5.size(), 0);

    repeat (2) tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/crc_engine_param.md
CRC_ENGINE_PARAM -- requirements
Module: crc_engine_param

Interface
REQ-001 The block SHALL have parameter CRC_W, default 16, giving the CRC register width (legal range 5..32).
REQ-002 The block SHALL have parameter POLY, default 16'h8005, giving the generator polynomial with the implicit x^CRC_W term omitted.
REQ-003 The block SHALL have parameter INIT, default all ones, giving the register value loaded at reset, on clear and on return to IDLE.
REQ-004 The block SHALL have parameter RESIDUAL, default 16'h800D, giving the raw register value that indicates a good frame in check mode.
REQ-005 Port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-006 Port n_rst, input, 1 bit: synchronous, active-low reset, sampled only on the rising edge of clk.
REQ-007 Port clear, input, 1 bit: synchronous abort; forces IDLE and reloads INIT.
REQ-008 Port bit_valid, input, 1 bit: qualifies bit_in for one cycle.
REQ-009 Port bit_in, input, 1 bit: serial data bit, in wire order.
REQ-010 Port data_end, input, 1 bit: marks the end of the payload and starts the send phase.
REQ-011 Port send_ready, input, 1 bit: the downstream consumer accepts serial_out this cycle.
REQ-012 Port serial_out, output, 1 bit: current CRC bit, MSB first.
REQ-013 Port serial_valid, output, 1 bit: serial_out is valid.
REQ-014 Port crc_value, output, CRC_W bits: the complemented register.
REQ-015 Port crc_ok, output, 1 bit: raw register equals RESIDUAL.
REQ-016 Port busy, output, 1 bit: asserted in any state other than IDLE.
REQ-017 Port done, output, 1 bit: single-cycle pulse when the last CRC bit is accepted.

Function
REQ-018 The block SHALL perform this update on every accepted bit: fb = bit_in ^ reg[CRC_W-1]; reg <= {reg[CRC_W-2:0],1'b0} ^ (fb ? POLY : 0).
REQ-019 The block SHALL use FSM states IDLE, CALC, SEND and DONE.
REQ-020 In IDLE, bit_valid SHALL update the register in the same cycle and move the FSM to CALC.
REQ-021 In IDLE, data_end SHALL go directly to SEND, which covers an empty payload.
REQ-022 In CALC, each bit_valid SHALL update the register.
REQ-023 In CALC, data_end SHALL move the FSM to SEND; if bit_valid is also high that cycle, the bit SHALL be absorbed first.
REQ-024 On entry to SEND, the block SHALL load a shift register with ~reg, including any same-cycle bit, and set a bit counter to CRC_W.
REQ-025 In SEND, serial_valid SHALL be 1 and serial_out SHALL equal shift[CRC_W-1].
REQ-026 In SEND, each cycle with send_ready high SHALL shift left by one and decrement the counter; with send_ready low, both SHALL hold.
REQ-027 The FSM SHALL move from SEND to DONE on the cycle the last bit is accepted, giving exactly CRC_W accepted cycles.
REQ-028 DONE SHALL last one cycle, assert done, then return to IDLE and reload INIT.
REQ-029 bit_valid and data_end SHALL be ignored in SEND and DONE.
REQ-030 crc_value SHALL be combinational ~reg and SHALL be frozen during SEND and DONE.
REQ-031 crc_ok SHALL be combinational (reg == RESIDUAL[CRC_W-1:0]) and is meaningful after a payload plus its transmitted CRC has been fed through bit_in.
REQ-032 Priority SHALL be: n_rst low, then clear, then the FSM; clear in any state, including mid-SEND, SHALL take effect on the next edge.

Reset
REQ-033 With n_rst low at a rising edge, the next state SHALL be: FSM IDLE, reg = INIT, shift = 0, counter = 0.
REQ-034 After reset, the outputs SHALL be serial_out=0, serial_valid=0, busy=0, done=0, and crc_value = ~INIT (0 for the default).
REQ-035 Deassertion of n_rst SHALL NOT change state before the next edge; there SHALL be no asynchronous path.

Verification
REQ-036 Scenario (CRC_W=5, POLY=5'h05, INIT=5'h1F, RESIDUAL=5'h0C): eleven 0 bits then data_end -> crc_value=5'b01000; serial_out sequence 0,1,0,0,0 with send_ready held high; done pulses one cycle after the fifth bit.
REQ-037 Scenario (same CRC5 configuration): feed eleven 0 bits followed by 0,1,0,0,0 -> raw reg=5'b01100 and crc_ok=1; flipping any one bit -> crc_ok=0.
REQ-038 Scenario (default CRC16): data_end in IDLE with no payload -> 16 serial bits all 0 and crc_value=16'h0000.
REQ-039 Scenario: send_ready toggling 1,0,0,1,... during SEND -> serial_out holds while send_ready is low, exactly CRC_W accepts occur, and serial_valid stays high throughout SEND.
REQ-040 Scenario: clear or n_rst low at the 8th SEND bit -> IDLE on the next edge, serial_valid=0, no done pulse, and a following frame computes correctly from INIT.
REQ-041 Scenario: bit_valid and data_end high in the same CALC cycle -> that bit is included in the CRC, checked against a reference model.
